// File: rtl/uart_tx_buf.sv
`timescale 1ns/1ps
// UART transmitter with a one-entry holding buffer.
// Bytes accepted on a valid/ready handshake wait in the holding register.
// Each byte is framed as: start bit, DBIT data bits LSB-first, an optional parity bit, then the stop period.
// Bit timing is taken from the shared 16x-oversampling baud tick.
module uart_tx_buf #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic [7:0] din,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
   localparam logic       PAR_ODD = (PARITY == 2);

   state_t     r_state, w_stateNext;
   logic [4:0] r_s, w_sNext;
   logic [2:0] r_n, w_nNext;
   logic [7:0] r_shift, w_shiftNext;
   logic [7:0] r_hold, w_holdNext;
   logic       r_holdFull, w_holdFullNext;
   logic       r_parBit, w_parBitNext;
   logic       r_tx, w_txNext;
   logic       r_done, w_doneNext;
   logic       w_load;
   logic       w_handshake;
   logic       w_parity;

   assign w_handshake  = tx_valid & ~r_holdFull;
   assign w_parity     = (^r_hold[DBIT-1:0]) ^ PAR_ODD;

   assign tx_ready     = ~r_holdFull;
   assign tx           = r_tx;
   assign tx_busy      = (r_state != IDLE);
   assign tx_done_tick = r_done;

   // State and datapath registers; reset aborts any frame and parks the line high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_s        <= '0;
         r_n        <= '0;
         r_shift    <= '0;
         r_hold     <= '0;
         r_holdFull <= 1'b0;
         r_parBit   <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_s        <= w_sNext;
         r_n        <= w_nNext;
         r_shift    <= w_shiftNext;
         r_hold     <= w_holdNext;
         r_holdFull <= w_holdFullNext;
         r_parBit   <= w_parBitNext;
         r_tx       <= w_txNext;
         r_done     <= w_doneNext;
      end
   end

   // Next-state logic: tick counting, bit sequencing, and buffer load/handshake.
   // The registered line level is derived from the next state, so tx changes on the same clk as the FSM.
   always_comb begin
      w_stateNext    = r_state;
      w_sNext        = r_s;
      w_nNext        = r_n;
      w_shiftNext    = r_shift;
      w_holdNext     = r_hold;
      w_holdFullNext = r_holdFull;
      w_parBitNext   = r_parBit;
      w_doneNext     = 1'b0;
      w_load         = 1'b0;
      w_txNext       = 1'b1;

      case (r_state)
         IDLE: begin
            w_load = r_holdFull;
         end
         START: begin
            if (s_tick) begin
               if (r_s == 5'd15) begin
                  w_sNext     = '0;
                  w_nNext     = '0;
                  w_stateNext = DATA;
               end else begin
                  w_sNext = r_s + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (r_s == 5'd15) begin
                  w_sNext     = '0;
                  w_shiftNext = {1'b0, r_shift[7:1]};
                  if (r_n == N_LAST) begin
                     w_stateNext = (PARITY != 0) ? PAR : STOP;
                  end else begin
                     w_nNext = r_n + 3'd1;
                  end
               end else begin
                  w_sNext = r_s + 5'd1;
               end
            end
         end
         PAR: begin
            if (s_tick) begin
               if (r_s == 5'd15) begin
                  w_sNext     = '0;
                  w_stateNext = STOP;
               end else begin
                  w_sNext = r_s + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (r_s == SB_LAST) begin
                  w_sNext    = '0;
                  w_doneNext = 1'b1;
                  if (r_holdFull) begin
                     w_load = 1'b1;
                  end else begin
                     w_stateNext = IDLE;
                  end
               end else begin
                  w_sNext = r_s + 5'd1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      if (w_load) begin
         w_shiftNext    = r_hold;
         w_parBitNext   = w_parity;
         w_holdFullNext = 1'b0;
         w_stateNext    = START;
         w_sNext        = '0;
      end

      if (w_handshake) begin
         w_holdNext     = din;
         w_holdFullNext = 1'b1;
      end

      case (w_stateNext)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_shiftNext[0];
         PAR:     w_txNext = w_parBitNext;
         default: w_txNext = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
// Testbench for uart_tx_buf.
// Five instances with different frame formats share the clock, reset and baud tick.
// A reference model decodes each serial line tick by tick.
// It compares each line against the frame the specification predicts for the bytes handed over.
module tb_uart_tx_buf;

   localparam int NUM = 5;
   localparam int DBITS [NUM] = '{8, 8, 8, 8, 5};
   localparam int SBS   [NUM] = '{16, 16, 16, 32, 24};
   localparam int PARS  [NUM] = '{0, 1, 2, 0, 2};

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick = 1'b0;
   logic [7:0] dinArr  [NUM];
   logic       txValid [NUM];
   logic       txReady [NUM];
   logic       txLine  [NUM];
   logic       txBusy  [NUM];
   logic       txDone  [NUM];

   int testsRun = 0;
   int testsFailed = 0;
   int tickPeriod = 4;
   bit stall = 1'b0;

   bit         inFrame    [NUM];
   int         tickCnt    [NUM];
   int         framesDone [NUM];
   int         hsCount    [NUM];
   int         pendCnt    [NUM];
   logic [7:0] curByte    [NUM];
   logic [7:0] pend       [NUM][2];

   for (genvar g = 0; g < NUM; g++) begin : gDut
      uart_tx_buf #(
         .DBIT(DBITS[g]),
         .SB_TICK(SBS[g]),
         .PARITY(PARS[g])
      ) dut (
         .clk(clk),
         .reset(reset),
         .s_tick(s_tick),
         .din(dinArr[g]),
         .tx_valid(txValid[g]),
         .tx_ready(txReady[g]),
         .tx(txLine[g]),
         .tx_busy(txBusy[g]),
         .tx_done_tick(txDone[g])
      );
   end

   // Free-running system clock.
   initial forever #5 clk = ~clk;

   // Baud tick generator: one pulse every tickPeriod clks, frozen while stall is set.
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk);
         #1;
         if (stall) begin
            s_tick = 1'b0;
         end else begin
            phase++;
            if (phase >= tickPeriod) phase = 0;
            s_tick = (phase == 0);
         end
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int frameLen(input int k);
      return 16 * (1 + DBITS[k] + ((PARS[k] != 0) ? 1 : 0)) + SBS[k];
   endfunction

   // Expected line level during the t-th tick (1-based) of a frame carrying byte b.
   function automatic int expBit(input int k, input logic [7:0] b, input int t);
      int seg;
      int ones;
      seg = (t - 1) / 16;
      if (seg == 0) return 0;
      if (seg <= DBITS[k]) return int'(b[seg-1]);
      if (PARS[k] != 0 && seg == DBITS[k] + 1) begin
         ones = 0;
         for (int i = 0; i < DBITS[k]; i++) ones += int'(b[i]);
         return (PARS[k] == 1) ? (ones % 2) : (1 - (ones % 2));
      end
      return 1;
   endfunction

   // Reference model: tracks accepted bytes, frame starts, tick positions and done pulses per instance.
   initial forever begin
      @(negedge clk);
      for (int k = 0; k < NUM; k++) begin
         if (reset !== 1'b1) begin
            inFrame[k] = 1'b0;
            pendCnt[k] = 0;
            tickCnt[k] = 0;
         end else begin
            if (txDone[k] && !inFrame[k]) checkOutput("strayDone", int'(txDone[k]), 0);
            if (txDone[k] && inFrame[k]) begin
               checkOutput("doneTick", tickCnt[k], frameLen(k));
               checkOutput("gapBusy", int'(txBusy[k]), (pendCnt[k] > 0) ? 1 : 0);
               checkOutput("gapTx", int'(txLine[k]), (pendCnt[k] > 0) ? 0 : 1);
               inFrame[k] = 1'b0;
               framesDone[k]++;
            end
            if (!inFrame[k] && txLine[k] == 1'b0) begin
               if (pendCnt[k] == 0) begin
                  checkOutput("unexpectedStart", int'(txLine[k]), 1);
                  curByte[k] = 8'h00;
               end else begin
                  curByte[k] = pend[k][0];
                  pend[k][0] = pend[k][1];
                  pendCnt[k]--;
               end
               inFrame[k] = 1'b1;
               tickCnt[k] = 0;
            end
            if (s_tick) begin
               if (inFrame[k]) begin
                  tickCnt[k]++;
                  if (tickCnt[k] <= frameLen(k)) begin
                     checkOutput("tx", int'(txLine[k]), expBit(k, curByte[k], tickCnt[k]));
                     checkOutput("busy", int'(txBusy[k]), 1);
                     checkOutput("ready", int'(txReady[k]), (pendCnt[k] == 0) ? 1 : 0);
                  end else begin
                     checkOutput("frameOverrun", tickCnt[k], frameLen(k));
                     inFrame[k] = 1'b0;
                  end
               end else begin
                  checkOutput("idleTx", int'(txLine[k]), 1);
               end
            end
            if (txValid[k] && txReady[k]) begin
               hsCount[k]++;
               if (pendCnt[k] < 2) begin
                  pend[k][pendCnt[k]] = dinArr[k];
                  pendCnt[k]++;
               end else begin
                  checkOutput("overflow", pendCnt[k], 1);
               end
            end
         end
      end
   end

   // Offer one byte to instance k and hold it until the handshake completes.
   task automatic applyStimulus(input int k, input logic [7:0] b);
      int waitCnt;
      bit accepted;
      waitCnt = 0;
      accepted = 1'b0;
      @(posedge clk);
      #1;
      dinArr[k] = b;
      txValid[k] = 1'b1;
      while (!accepted && waitCnt < 4000) begin
         @(negedge clk);
         if (txReady[k]) accepted = 1'b1;
         waitCnt++;
         @(posedge clk);
         #1;
      end
      txValid[k] = 1'b0;
      if (!accepted) checkOutput("handshakeTimeout", 0, 1);
   endtask

   task automatic waitFrames(input int k, input int target);
      int c;
      c = 0;
      while (framesDone[k] < target && c < 20000) begin
         @(negedge clk);
         c++;
      end
      checkOutput("frameCount", framesDone[k], target);
   endtask

   task automatic waitTick(input int k, input int n);
      int c;
      c = 0;
      while (!(inFrame[k] && tickCnt[k] >= n) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      checkOutput("tickReached", (inFrame[k] && tickCnt[k] >= n) ? 1 : 0, 1);
   endtask

   task automatic checkIdle(input int k);
      repeat (2) @(negedge clk);
      checkOutput("idleReady", int'(txReady[k]), 1);
      checkOutput("idleBusy", int'(txBusy[k]), 0);
      checkOutput("idleLine", int'(txLine[k]), 1);
   endtask

   // Directed scenarios followed by randomized traffic across all frame formats.
   initial begin
      int base;
      int hsBefore;
      int held;
      int k;
      int nExp;
      logic [7:0] b1;
      logic [7:0] b2;

      reset = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         dinArr[i] = 8'h00;
         txValid[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
         checkOutput("resetTx", int'(txLine[i]), 1);
         checkOutput("resetReady", int'(txReady[i]), 1);
         checkOutput("resetBusy", int'(txBusy[i]), 0);
         checkOutput("resetDone", int'(txDone[i]), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;

      // 8N1 frame of 0xA5.
      applyStimulus(0, 8'hA5);
      waitFrames(0, 1);
      checkIdle(0);

      // Even and odd parity frames of 0xA5.
      applyStimulus(1, 8'hA5);
      waitFrames(1, 1);
      checkIdle(1);
      applyStimulus(2, 8'hA5);
      waitFrames(2, 1);
      checkIdle(2);

      // Back-to-back: second byte accepted while the first frame is in its data bits.
      applyStimulus(0, 8'h3C);
      waitTick(0, 20);
      applyStimulus(0, 8'hF0);
      repeat (2) @(negedge clk);
      checkOutput("b2bReadyLow", int'(txReady[0]), 0);
      waitFrames(0, 3);
      checkIdle(0);

      // Backpressure: 0x55 is held on the bus while the buffer is full.
      hsBefore = hsCount[0];
      applyStimulus(0, 8'h11);
      applyStimulus(0, 8'h22);
      applyStimulus(0, 8'h55);
      waitFrames(0, 6);
      checkOutput("hsCount", hsCount[0] - hsBefore, 3);
      checkIdle(0);

      // Asynchronous reset during data bit 3 of 0xFF, then a clean frame of 0x81.
      base = framesDone[0];
      applyStimulus(0, 8'hFF);
      waitTick(0, 72);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("abortTx", int'(txLine[0]), 1);
      checkOutput("abortReady", int'(txReady[0]), 1);
      checkOutput("abortBusy", int'(txBusy[0]), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(0, 8'h81);
      waitFrames(0, base + 1);
      checkIdle(0);

      // Two stop bits with the baud tick stalled for 50 clks mid data bit.
      applyStimulus(3, 8'h6B);
      waitTick(3, 53);
      @(posedge clk);
      #1;
      stall = 1'b1;
      @(negedge clk);
      held = int'(txLine[3]);
      checkOutput("stallLevel", held, 0);
      for (int i = 0; i < 5; i++) begin
         repeat (10) @(negedge clk);
         checkOutput("stallHold", int'(txLine[3]), held);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      waitFrames(3, 1);
      checkIdle(3);

      // Randomized traffic: single or back-to-back bytes with varied tick spacing.
      for (int it = 0; it < 12; it++) begin
         k = $urandom_range(0, NUM - 1);
         tickPeriod = $urandom_range(2, 6);
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         base = framesDone[k];
         nExp = 1;
         applyStimulus(k, b1);
         if ($urandom_range(0, 1) == 1) begin
            applyStimulus(k, b2);
            nExp = 2;
         end
         waitFrames(k, base + nExp);
         checkIdle(k);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- UART transmitter with a one-entry holding buffer. It serialises parallel bytes into asynchronous frames on `tx`.
- Frame format: start bit, DBIT data bits LSB-first, optional parity bit, stop period.
- Paced by the shared 16x-oversampling baud tick `s_tick`, the same tick generator that drives the receive side.
- Sits between the host-side byte source (valid/ready) and the serial line.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..8; low DBIT bits of `din` are sent.
- SB_TICK, 16, stop-period length in `s_tick` pulses; 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal range 16..32.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- s_tick  input  1  one-clk-wide pulse at 16x baud rate.
- din  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  source has a byte on `din`.
- tx_ready  output  1  holding buffer empty; handshake occurs when tx_valid & tx_ready.
- tx  output  1  serial line; registered output; idle high.
- tx_busy  output  1  high whenever the FSM is not in idle.
- tx_done_tick  output  1  one-clk pulse when a frame's stop period completes.

Behaviour:
- Reset (reset=0, asynchronous): FSM = idle, tx = 1, tx_ready = 1, tx_busy = 0, tx_done_tick = 0; all counters, the shift register and the holding register are cleared. This applies mid-frame: the frame is aborted immediately and `tx` returns high with no glitch low.
- Holding buffer:
  - On handshake, `din` is latched into the holding register; hold_full is set and tx_ready drops on the next clk.
  - tx_valid while tx_ready = 0 is ignored; the source must hold `din` and tx_valid.
- Load:
  - Trigger: FSM in idle with hold_full, or the stop period completing with hold_full.
  - On that clk: holding register -> shift register, hold_full is cleared, FSM -> start, tx = 0.
  - Same-cycle handshake and load: the new byte enters the holding register, and the buffered byte moves to the shift register.
- Counters:
  - Tick counter s: 5 bits, advances only on clks where s_tick = 1.
  - Bit counter n: 3 bits.
  - With no s_tick the FSM and `tx` hold their values.
- States:
  - idle: tx = 1; leave as described under Load.
  - start: tx = 0. On s_tick with s = 15: s = 0, n = 0, FSM -> data, tx = shift[0].
  - data: tx = shift[0]. On s_tick with s = 15: s = 0 and the shift register shifts right.
    - If n = DBIT-1: FSM -> parity when PARITY != 0, else FSM -> stop.
    - Otherwise n = n+1.
  - parity: tx = XOR of the DBIT data bits for even parity, inverted for odd. Lasts 16 ticks, then FSM -> stop.
  - stop: tx = 1. On s_tick with s = SB_TICK-1:
    - tx_done_tick = 1 for that clk.
    - FSM -> start if hold_full (no idle gap), else FSM -> idle.
- Timing:
  - The first tick counted in start is the first s_tick after the load clk.
  - Frame duration = 16*(1+DBIT+(PARITY!=0)) + SB_TICK ticks.
- Parity is computed from the shift-register contents captured at load, not by reading `din` again.
- tx_busy = (FSM != idle); it stays high across back-to-back frames.

Test Plan:
- DBIT=8, PARITY=0, send 0xA5 with s_tick every 4 clks:
  - tx sequence, 16 ticks each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - tx_done_tick pulses once, at tick 160.
  - tx_busy is high throughout the frame; FSM returns to idle and tx_ready = 1.
- PARITY=1 then PARITY=2, send 0xA5 (four ones): parity bit is 0 for even, 1 for odd. Frame = 176 ticks; stop is high for 16 ticks.
- Back-to-back 0x3C then 0xF0:
  - Handshake 0x3C; the second handshake is accepted while the first frame is in data.
  - tx_ready then stays 0 until the first frame's stop ends.
  - The second start bit begins on the same clk that tx_done_tick pulses; tx never idles between frames.
- Backpressure: hold tx_valid with 0x55 while the buffer is full. Exactly one frame of 0x55 follows the earlier frame; no duplicate or lost byte.
- reset driven to 0 at data bit 3 of 0xFF: tx = 1 asynchronously, tx_ready = 1, tx_busy = 0. After release, send 0x81; it is framed correctly with no residue from the aborted frame.
- SB_TICK=32 with s_tick stalled for 50 clks mid-data bit: `tx` holds its value during the stall; stop lasts 32 ticks; total frame = 176 ticks.
